// File: rtl/core_mem_arbiter_if.sv
// Shared types and the core/RAM bus bundle for core_mem_arbiter.
// The master modport is the core+RAM side; the slave modport is the arbiter.
package core_mem_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface core_mem_arbiter_if;
  import core_mem_arbiter_pkg::*;

  logic      [1:0] iREN;
  word_t     [1:0] iaddr;
  logic      [1:0] dREN;
  logic      [1:0] dWEN;
  word_t     [1:0] daddr;
  word_t     [1:0] dstore;
  logic      [1:0] iwait;
  logic      [1:0] dwait;
  word_t     [1:0] iload;
  word_t     [1:0] dload;
  ramstate_t       ramstate;
  word_t           ramload;
  word_t           ramaddr;
  word_t           ramstore;
  logic            ramREN;
  logic            ramWEN;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-core arbiter sharing one RAM port among I0, D0, I1, D1 (IDLE/SERVE FSM).
// Define ARB_ROUND_ROBIN_EN to break inter-core ties in favour of the core not served last.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  core_mem_arbiter_if.slave    bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  typedef struct packed {
    logic core;
    logic data;
  } owner_t;

  state_t state, next_state;
  owner_t owner, next_owner;
  logic   last_core, next_last_core;

  logic [1:0] dreq;
  logic [1:0] req;
  logic       tie_core;
  logic       pick_core;
  logic       owner_req;

  assign dreq = bus.dREN | bus.dWEN;
  assign req  = dreq | bus.iREN;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_core = ~last_core;
`else
  assign tie_core = 1'b0;
`endif

  assign pick_core = (req[0] && req[1]) ? tie_core : req[1];
  assign owner_req = owner.data ? dreq[owner.core] : bus.iREN[owner.core];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      owner     <= '0;
      last_core <= 1'b1;
    end else begin
      state     <= next_state;
      owner     <= next_owner;
      last_core <= next_last_core;
    end
  end

  always_comb begin
    next_state     = state;
    next_owner     = owner;
    next_last_core = last_core;
    bus.iwait      = '1;
    bus.dwait      = '1;
    bus.iload      = '0;
    bus.dload      = '0;
    bus.ramaddr    = '0;
    bus.ramstore   = '0;
    bus.ramREN     = 1'b0;
    bus.ramWEN     = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          next_state      = SERVE;
          next_owner.core = pick_core;
          next_owner.data = dreq[pick_core];
        end
      end

      SERVE: begin
        // A dropped request aborts silently: strobes stay low and no wait pulse.
        if (!owner_req) begin
          next_state = IDLE;
        end else begin
          if (owner.data) begin
            bus.ramaddr  = bus.daddr[owner.core];
            bus.ramstore = bus.dstore[owner.core];
            bus.ramWEN   = bus.dWEN[owner.core];
            bus.ramREN   = ~bus.dWEN[owner.core];
          end else begin
            bus.ramaddr  = bus.iaddr[owner.core];
            bus.ramREN   = 1'b1;
          end

          if (bus.ramstate == ACCESS) begin
            if (owner.data) begin
              bus.dwait[owner.core] = 1'b0;
              bus.dload[owner.core] = bus.ramload;
            end else begin
              bus.iwait[owner.core] = 1'b0;
              bus.iload[owner.core] = bus.ramload;
            end
            next_last_core = owner.core;
            next_state     = IDLE;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

  a_strobes_exclusive: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.ramREN && bus.ramWEN));

  a_last_core_tracks: assert property (@(posedge CLK) disable iff (!nRST)
    (state == SERVE && owner_req && bus.ramstate == ACCESS) |=> (last_core == $past(owner.core)));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter.
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  logic CLK;
  logic nRST;
  int unsigned checks;
  int unsigned errors;

  core_mem_arbiter_if bus();

  core_mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    bus.ramload  = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] exp_addr [4];

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    clear_inputs();

    // Reset state
    tick();
    tick();
    check("rst_iwait", {30'd0, bus.iwait}, 32'h3);
    check("rst_dwait", {30'd0, bus.dwait}, 32'h3);
    check("rst_ramren", {31'd0, bus.ramREN}, 32'h0);
    check("rst_ramwen", {31'd0, bus.ramWEN}, 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_dload0", bus.dload[0], 32'h0);
    nRST = 1'b1;

    // Single read with ACCESS on the third SERVE cycle
    tick();
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h100;
    settle();
    check("rd_arb_ren", {31'd0, bus.ramREN}, 32'h0);
    check("rd_arb_dwait", {30'd0, bus.dwait}, 32'h3);
    tick();
    bus.ramstate = BUSY;
    settle();
    check("rd_s1_ren", {31'd0, bus.ramREN}, 32'h1);
    check("rd_s1_addr", bus.ramaddr, 32'h100);
    check("rd_s1_dwait", {30'd0, bus.dwait}, 32'h3);
    tick();
    settle();
    check("rd_s2_dwait", {30'd0, bus.dwait}, 32'h3);
    check("rd_s2_dload0", bus.dload[0], 32'h0);
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    settle();
    check("rd_s3_dwait", {30'd0, bus.dwait}, 32'h2);
    check("rd_s3_dload0", bus.dload[0], 32'hDEADBEEF);
    check("rd_s3_dload1", bus.dload[1], 32'h0);
    check("rd_s3_iwait", {30'd0, bus.iwait}, 32'h3);
    clear_inputs();
    tick();
    settle();
    check("rd_done_dwait", {30'd0, bus.dwait}, 32'h3);
    check("rd_done_dload0", bus.dload[0], 32'h0);
    check("rd_done_ren", {31'd0, bus.ramREN}, 32'h0);

    // Intra-core priority: D1 write beats I1, write wins over read
    bus.iREN[1]   = 1'b1;
    bus.iaddr[1]  = 32'h300;
    bus.dWEN[1]   = 1'b1;
    bus.dREN[1]   = 1'b1;
    bus.daddr[1]  = 32'h200;
    bus.dstore[1] = 32'h5;
    bus.ramstate  = ACCESS;
    bus.ramload   = 32'h12345678;
    settle();
    check("pri_arb_wen", {31'd0, bus.ramWEN}, 32'h0);
    tick();
    check("pri_d_wen", {31'd0, bus.ramWEN}, 32'h1);
    check("pri_d_ren", {31'd0, bus.ramREN}, 32'h0);
    check("pri_d_store", bus.ramstore, 32'h5);
    check("pri_d_addr", bus.ramaddr, 32'h200);
    check("pri_d_dwait", {30'd0, bus.dwait}, 32'h1);
    check("pri_d_iwait", {30'd0, bus.iwait}, 32'h3);
    bus.dWEN[1] = 1'b0;
    bus.dREN[1] = 1'b0;
    tick();
    check("pri_gap_ren", {31'd0, bus.ramREN}, 32'h0);
    check("pri_gap_iwait", {30'd0, bus.iwait}, 32'h3);
    tick();
    check("pri_i_ren", {31'd0, bus.ramREN}, 32'h1);
    check("pri_i_addr", bus.ramaddr, 32'h300);
    check("pri_i_iwait", {30'd0, bus.iwait}, 32'h1);
    check("pri_i_iload1", bus.iload[1], 32'h12345678);
    clear_inputs();
    tick();

    // Inter-core tie with all four sources held; last served core is 1 here
    bus.iREN     = 2'b11;
    bus.dREN     = 2'b11;
    bus.iaddr[0] = 32'h10;
    bus.daddr[0] = 32'h20;
    bus.iaddr[1] = 32'h30;
    bus.daddr[1] = 32'h40;
    bus.ramstate = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h20, 32'h40, 32'h20, 32'h40};
`else
    exp_addr = '{32'h20, 32'h20, 32'h20, 32'h20};
`endif
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("tie_grant%0d_addr", g), bus.ramaddr, exp_addr[g]);
      tick();
      check($sformatf("tie_gap%0d_ren", g), {31'd0, bus.ramREN}, 32'h0);
    end
    clear_inputs();
    tick();

    // Abort: I0 drops its request while RAM is busy
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h50;
    bus.ramstate = BUSY;
    tick();
    check("abt_s_ren", {31'd0, bus.ramREN}, 32'h1);
    check("abt_s_addr", bus.ramaddr, 32'h50);
    bus.iREN[0] = 1'b0;
    settle();
    check("abt_cyc_ren", {31'd0, bus.ramREN}, 32'h0);
    check("abt_cyc_iwait", {30'd0, bus.iwait}, 32'h3);
    bus.ramstate = ACCESS;
    tick();
    check("abt_idle_ren", {31'd0, bus.ramREN}, 32'h0);
    check("abt_idle_iwait", {30'd0, bus.iwait}, 32'h3);
    clear_inputs();
    tick();

    // ERROR twice, then ACCESS
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h60;
    bus.dstore[0] = 32'hA5A5;
    bus.ramstate  = ERROR;
    tick();
    check("err1_wen", {31'd0, bus.ramWEN}, 32'h1);
    check("err1_dwait", {30'd0, bus.dwait}, 32'h3);
    tick();
    check("err2_wen", {31'd0, bus.ramWEN}, 32'h1);
    check("err2_store", bus.ramstore, 32'hA5A5);
    check("err2_dwait", {30'd0, bus.dwait}, 32'h3);
    tick();
    bus.ramstate = ACCESS;
    settle();
    check("err_acc_dwait", {30'd0, bus.dwait}, 32'h2);
    clear_inputs();
    tick();
    check("err_done_dwait", {30'd0, bus.dwait}, 32'h3);
    check("err_done_wen", {31'd0, bus.ramWEN}, 32'h0);

    // Asynchronous reset in the middle of a write
    bus.dWEN[1]   = 1'b1;
    bus.daddr[1]  = 32'h70;
    bus.dstore[1] = 32'h77;
    bus.ramstate  = BUSY;
    tick();
    check("ar_pre_wen", {31'd0, bus.ramWEN}, 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    check("ar_wen", {31'd0, bus.ramWEN}, 32'h0);
    check("ar_addr", bus.ramaddr, 32'h0);
    check("ar_store", bus.ramstore, 32'h0);
    check("ar_dwait", {30'd0, bus.dwait}, 32'h3);
    check("ar_iwait", {30'd0, bus.iwait}, 32'h3);
    clear_inputs();
    tick();
    nRST = 1'b1;
    tick();
    check("ar_after_ren", {31'd0, bus.ramREN}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  asynchronous, active-low reset.
REQ-003 iREN[1:0]  input  2  per-core instruction read request (index = core id).
REQ-004 iaddr[1:0]  input  2x32 (word_t)  per-core instruction address.
REQ-005 dREN[1:0], dWEN[1:0]  input  2+2  per-core data read/write request.
REQ-006 daddr[1:0], dstore[1:0]  input  2x32 each  per-core data address and write data.
REQ-007 iwait[1:0], dwait[1:0]  output  2+2  per-source stall; low for exactly the completion cycle.
REQ-008 iload[1:0], dload[1:0]  output  2x32 each  per-source read data; valid when the matching wait is low.
REQ-009 ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.
REQ-010 ramload  input  32  RAM read data.
REQ-011 ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-012 ramREN, ramWEN  output  1 each  RAM read/write strobes; never both high.

Function
REQ-013 The block SHALL share one RAM port among four sources: I0, D0, I1, D1.
REQ-014 The FSM SHALL have exactly two states, IDLE and SERVE, plus registers owner (core id and i/d type) and last_core.
REQ-015 In IDLE, ram outputs SHALL be 0 and all waits SHALL be 1.
REQ-016 In IDLE, any active request SHALL cause an arbitration decision to be latched into owner, with a transition to SERVE on the next edge.
REQ-017 Within a core, a data request SHALL take priority over an instruction request.
REQ-018 Between cores, arbitration SHALL follow REQ-031 when both cores request.
REQ-019 In SERVE, ramaddr, ramstore, ramREN and ramWEN SHALL be driven combinationally from the owner's current inputs.
REQ-020 A data owner with dWEN=1 SHALL issue a write (ramWEN=1, ramREN=0) even if dREN=1.
REQ-021 A data owner with dREN=1 and dWEN=0 SHALL issue a read.
REQ-022 An instruction owner SHALL always issue a read.
REQ-023 In SERVE with ramstate==ACCESS, the owner's wait SHALL be 0 in that same cycle.
REQ-024 On that completion cycle, the owner's load SHALL equal ramload, last_core SHALL be set to the owner's core, and the FSM SHALL return to IDLE.
REQ-025 In SERVE with ramstate FREE, BUSY or ERROR, the FSM SHALL stay in SERVE, keep the owner's wait at 1 and keep requesting (ERROR means retry).
REQ-026 If the owner's request drops in SERVE, the FSM SHALL return to IDLE next edge with ram strobes 0 in that cycle and no wait pulse.
REQ-027 Non-owner waits SHALL stay 1 throughout; non-owner loads SHALL be 0.
REQ-028 Minimum service time SHALL be 2 cycles: one arbitration cycle plus at least one SERVE cycle.
REQ-029 A request held after completion SHALL re-arbitrate from IDLE; back-to-back grants SHALL therefore be separated by one IDLE cycle.

Reset
REQ-030 While nRST=0: state=IDLE, owner=I0, last_core=1, all waits=1, all loads=0, and ramaddr, ramstore, ramREN, ramWEN = 0; reset mid-SERVE SHALL abort the access immediately.

Configuration
REQ-031 With ARB_ROUND_ROBIN_EN defined, a tie between cores SHALL go to the core not equal to last_core; without it, core 0 SHALL always win ties and last_core SHALL still be tracked but ignored.

Verification
REQ-032 Single read: dREN[0]=1, daddr[0]=0x100, ACCESS on the 3rd SERVE cycle with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 from cycle 1; dwait[0]=0 and dload[0]=0xDEADBEEF only in the ACCESS cycle.
REQ-033 Intra-core priority: iREN[1]=1 and dWEN[1]=1 with dstore=0x5, immediate ACCESS -> data write served first (ramWEN=1, ramstore=0x5); I1 served after one IDLE cycle.
REQ-034 Inter-core tie, macro defined: all four sources held, ACCESS every SERVE cycle -> grant order D0, D1, D0, D1; without the macro -> D0, D0, ... and core 1 starves.
REQ-035 Abort: I0 granted, iREN[0] dropped while ramstate=BUSY -> IDLE next cycle, iwait[0] never 0, ram strobes 0 in the abort cycle.
REQ-036 ERROR retry: ramstate=ERROR for 2 cycles, then ACCESS -> remains in SERVE, strobes held, single wait pulse on ACCESS.
REQ-037 Reset mid-SERVE: nRST low asynchronously during a write -> ramWEN falls without waiting for an edge; all outputs at REQ-030 values.
